// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered N-source bus multiplexer with fixed or
// round-robin priority, multi-driver conflict flag and a saturating
// conflict counter for debug.
module bus_arbiter_mux #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 24,
    parameter int CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   rr_mode,
    output logic [WIDTH-1:0]       bus_out,
    output logic [N_SRC-1:0]       grant,
    output logic                   bus_valid,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_count
);

    localparam int IDX_W = $clog2(N_SRC);

    // Candidate index examined at search step k. Round-robin starts just
    // after the last grant and wraps, so the last grantee is looked at last.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [IDX_W-1:0] lp,
                                                  input logic rr,
                                                  input int k);
        int s;
        if (rr) begin
            s = int'(lp) + 1 + k;
            if (s >= N_SRC) begin
                s = s - N_SRC;
            end
        end else begin
            s = k;
        end
        return IDX_W'(s);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] bus_out_q,   bus_out_d;
    logic [N_SRC-1:0] grant_q,     grant_d;
    logic             bus_valid_q, bus_valid_d;
    logic             conflict_q,  conflict_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [IDX_W-1:0] lp_q,        lp_d;

    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_word;
    logic             multi;

    // Arbitration: first requester in search order wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && src_out[pick_idx(lp_q, rr_mode, k)]) begin
                found   = 1'b1;
                win_idx = pick_idx(lp_q, rr_mode, k);
            end
        end
    end

    // Route the winning source word (constant slices keep the mux simple).
    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_word = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign multi = (src_out & (src_out - 1'b1)) != '0;

    // Next-state: load on any request, otherwise hold the bus and go idle.
    always_comb begin
        bus_out_d   = bus_out_q;
        grant_d     = '0;
        bus_valid_d = 1'b0;
        lp_d        = lp_q;
        conflict_d  = multi;
        count_d     = multi ? sat_inc(count_q) : count_q;
        if (found) begin
            bus_out_d        = win_word;
            grant_d[win_idx] = 1'b1;
            bus_valid_d      = 1'b1;
            lp_d             = win_idx;
        end
    end

    // State registers; clear dominates every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_out_q   <= '0;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            count_q     <= '0;
            lp_q        <= IDX_W'(N_SRC - 1);
        end else begin
            bus_out_q   <= bus_out_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
            conflict_q  <= conflict_d;
            count_q     <= count_d;
            lp_q        <= lp_d;
        end
    end

    assign bus_out        = bus_out_q;
    assign grant          = grant_q;
    assign bus_valid      = bus_valid_q;
    assign conflict       = conflict_q;
    assign conflict_count = count_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Testbench for bus_arbiter_mux: directed scenarios with hand-derived
// expectations plus randomized traffic against a behavioural model.
module tb_bus_arbiter_mux;

    localparam int W  = 32;
    localparam int N  = 24;
    localparam int CW = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             clear;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_out;
    logic             rr_mode;
    logic [W-1:0]     bus_out;
    logic [N-1:0]     grant;
    logic             bus_valid;
    logic             conflict;
    logic [CW-1:0]    conflict_count;

    // Small instance for counter saturation with CNT_W=2.
    logic [15:0]      s_data;
    logic [1:0]       s_out;
    logic             s_rr;
    logic [7:0]       s_bus;
    logic [1:0]       s_grant;
    logic             s_valid;
    logic             s_conf;
    logic [1:0]       s_cnt;

    bus_arbiter_mux #(.WIDTH(W), .N_SRC(N), .CNT_W(CW)) dut (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .rr_mode(rr_mode), .bus_out(bus_out), .grant(grant), .bus_valid(bus_valid),
        .conflict(conflict), .conflict_count(conflict_count)
    );

    bus_arbiter_mux #(.WIDTH(8), .N_SRC(2), .CNT_W(2)) dut_small (
        .clock(clock), .clear(clear), .src_data(s_data), .src_out(s_out),
        .rr_mode(s_rr), .bus_out(s_bus), .grant(s_grant), .bus_valid(s_valid),
        .conflict(s_conf), .conflict_count(s_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [W-1:0] m_bus;
    logic [N-1:0] m_grant;
    logic         m_valid;
    logic         m_conf;
    int           m_cnt;
    int           m_lp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Apply the rules to the inputs present at the clock edge.
    task automatic model_edge();
        int win;
        if (clear) begin
            m_bus = '0; m_grant = '0; m_valid = 1'b0; m_conf = 1'b0;
            m_cnt = 0; m_lp = N - 1;
        end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = rr_mode ? (m_lp + 1 + k) % N : k;
                if (win < 0 && src_out[idx]) win = idx;
            end
            m_conf = ($countones(src_out) >= 2);
            if (m_conf && m_cnt < (1 << CW) - 1) m_cnt++;
            m_grant = '0;
            if (win >= 0) begin
                m_bus        = src_data[win*W +: W];
                m_grant[win] = 1'b1;
                m_valid      = 1'b1;
                m_lp         = win;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        chk("m_bus",   64'(bus_out),        64'(m_bus));
        chk("m_grant", 64'(grant),          64'(m_grant));
        chk("m_valid", 64'(bus_valid),      64'(m_valid));
        chk("m_conf",  64'(conflict),       64'(m_conf));
        chk("m_cnt",   64'(conflict_count), 64'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    int exp_seq [5] = '{1, 4, 23, 1, 4};
    int sat_seq [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        clear    = 1'b1;
        rr_mode  = 1'b0;
        src_out  = '0;
        s_out    = '0;
        s_rr     = 1'b0;
        s_data   = 16'hB2A1;
        for (int i = 0; i < N; i++) set_word(i, $urandom);
        m_bus = '0; m_grant = '0; m_valid = 0; m_conf = 0; m_cnt = 0; m_lp = N - 1;

        // Reset and idle.
        tick(); tick();
        chk("rst_bus",   64'(bus_out), 0);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_valid", 64'(bus_valid), 0);
        chk("rst_cnt",   64'(conflict_count), 0);
        clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_bus",   64'(bus_out), 0);
            chk("idle_grant", 64'(grant), 0);
            chk("idle_valid", 64'(bus_valid), 0);
            chk("idle_cnt",   64'(conflict_count), 0);
        end

        // Single driver, latency and hold.
        set_word(3, 32'hDEADBEEF);
        src_out = 24'h000008;
        tick();
        chk("single_bus",   64'(bus_out), 64'hDEADBEEF);
        chk("single_grant", 64'(grant), 64'h000008);
        chk("single_valid", 64'(bus_valid), 1);
        src_out = '0;
        tick();
        chk("hold_bus",   64'(bus_out), 64'hDEADBEEF);
        chk("hold_valid", 64'(bus_valid), 0);
        chk("hold_grant", 64'(grant), 0);

        // Fixed-priority conflict.
        set_word(5, 32'h11);
        set_word(20, 32'h22);
        src_out = (24'd1 << 5) | (24'd1 << 20);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("fix_bus",   64'(bus_out), 64'h11);
            chk("fix_grant", 64'(grant), 64'(24'd1 << 5));
            chk("fix_conf",  64'(conflict), 1);
            chk("fix_cnt",   64'(conflict_count), 64'(c));
        end

        // Round-robin fairness with wrap-around.
        clear = 1'b1; src_out = '0;
        tick();
        clear = 1'b0;
        rr_mode = 1'b1;
        src_out = (24'd1 << 1) | (24'd1 << 4) | (24'd1 << 23);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rr_grant", 64'(grant), 64'(24'd1 << exp_seq[c]));
        end

        // Clear mid-operation (last grant was index 4).
        clear = 1'b1;
        tick();
        chk("mid_bus",   64'(bus_out), 0);
        chk("mid_grant", 64'(grant), 0);
        chk("mid_valid", 64'(bus_valid), 0);
        chk("mid_conf",  64'(conflict), 0);
        chk("mid_cnt",   64'(conflict_count), 0);
        clear = 1'b0;
        tick();
        chk("mid_next1", 64'(grant), 64'(24'd1 << 1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        src_out = src_out | 24'd1;
        tick();
        chk("mid_next0", 64'(grant), 64'h1);

        // Saturation on the 2-bit counter instance.
        s_out = 2'b11;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("sat_cnt",   64'(s_cnt), 64'(sat_seq[c]));
            chk("sat_bus",   64'(s_bus), 64'hA1);
            chk("sat_grant", 64'(s_grant), 64'h1);
            chk("sat_conf",  64'(s_conf), 1);
        end
        s_out = '0;

        // Random traffic: sparse requests, mode flips, occasional clear.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) set_word(i, $urandom);
            src_out = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 4) == 0) src_out = '0;
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear = 1'b0;

        // Dense requests: counter must climb to and stick at all-ones.
        for (int c = 0; c < 320; c++) begin
            for (int i = 0; i < N; i++) set_word(i, $urandom);
            src_out = N'($urandom) | 24'h000003;
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            tick();
        end
        chk("cnt_sat", 64'(conflict_count), 64'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
